// File: rtl/mod_pkg.sv
// Shared definitions for the bit-serial modulation transmit path:
// frame state encoding and default frame geometry.
package mod_pkg;

    localparam int unsigned MSG_W_DEF     = 8;
    localparam int unsigned BIT_TICKS_DEF = 4;
    localparam int unsigned PRE_LEN_DEF   = 4;
    localparam int unsigned GAP_TICKS_DEF = 8;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        GAP  = 3'd4
    } state_t;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mod_bit_timer.sv
// Tick counter with clear and a programmable terminal count; bit_end marks
// the last tick of the current interval and the counter wraps to zero there.
module mod_bit_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             run,
    input  logic [CNT_W-1:0] tc,
    output logic             bit_end
);

    logic [CNT_W-1:0] tick_cnt;

    assign bit_end = run && (tick_cnt == tc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (clr) begin
            tick_cnt <= '0;
        end else if (run) begin
            tick_cnt <= bit_end ? '0 : tick_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mod_tx_sequencer.sv
// Frame controller: preamble, MSB-first message bits from the external shift
// register, even parity, then an idle gap; done pulses on normal completion.
module mod_tx_sequencer
    import mod_pkg::*;
#(
    parameter int unsigned MSG_W     = MSG_W_DEF,
    parameter int unsigned BIT_TICKS = BIT_TICKS_DEF,
    parameter int unsigned PRE_LEN   = PRE_LEN_DEF,
    parameter int unsigned GAP_TICKS = GAP_TICKS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic send,
    input  logic abort,
    input  logic ser_in,
    output logic ld,
    output logic en,
    output logic tx_bit,
    output logic tx_valid,
    output logic busy,
    output logic done
);

    localparam int unsigned TICK_W = $clog2(max2(BIT_TICKS, GAP_TICKS)) + 1;
    localparam int unsigned BIT_W  = $clog2(max2(PRE_LEN, MSG_W)) + 1;

    state_t            state, state_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic              parity, parity_nxt;
    logic              done_nxt;
    logic              bit_end;
    logic              tmr_clr;
    logic              tmr_run;
    logic [TICK_W-1:0] tmr_tc;

    // One timer serves both symbol timing and the gap; only the terminal count changes.
    assign tmr_run = (state != IDLE);
    assign tmr_clr = (state == IDLE) || abort;
    assign tmr_tc  = (state == GAP) ? TICK_W'(GAP_TICKS - 1) : TICK_W'(BIT_TICKS - 1);

    mod_bit_timer #(
        .CNT_W (TICK_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmr_clr),
        .run     (tmr_run),
        .tc      (tmr_tc),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            parity  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            parity  <= parity_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        parity_nxt  = parity;
        done_nxt    = 1'b0;
        ld          = 1'b0;
        en          = 1'b0;
        tx_bit      = 1'b0;
        tx_valid    = 1'b0;
        busy        = 1'b1;

        case (state)
            IDLE: begin
                busy = 1'b0;
                ld   = 1'b1;
                if (send && !abort) begin
                    state_nxt   = PRE;
                    bit_cnt_nxt = '0;
                    parity_nxt  = 1'b0;
                end
            end
            PRE: begin
                tx_valid = 1'b1;
                tx_bit   = ~bit_cnt[0];
                if (bit_end) begin
                    if (bit_cnt == BIT_W'(PRE_LEN - 1)) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    end
                end
            end
            DATA: begin
                tx_valid = 1'b1;
                tx_bit   = ser_in;
                en       = bit_end && !abort;
                if (bit_end) begin
                    parity_nxt = parity ^ ser_in;
                    if (bit_cnt == BIT_W'(MSG_W - 1)) begin
                        state_nxt   = PAR;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    end
                end
            end
            PAR: begin
                tx_valid = 1'b1;
                tx_bit   = parity;
                if (bit_end) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase

        // Abort overrides every transition and suppresses done.
        if (abort && (state != IDLE)) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            parity_nxt  = 1'b0;
            done_nxt    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_tx_sequencer.sv
// Bench for mod_tx_sequencer: models the message shift register, queues the
// expected symbol stream and frame length per frame, and checks them on output.
module tb_mod_tx_sequencer;
    import mod_pkg::*;

    localparam int unsigned MSG_W     = MSG_W_DEF;
    localparam int unsigned BIT_TICKS = BIT_TICKS_DEF;
    localparam int unsigned PRE_LEN   = PRE_LEN_DEF;
    localparam int unsigned GAP_TICKS = GAP_TICKS_DEF;
    localparam int unsigned FRAME_LEN = (PRE_LEN + MSG_W + 1) * BIT_TICKS + GAP_TICKS;

    typedef struct packed {
        logic b;
        logic is_data;
    } sym_t;

    logic clk = 1'b0;
    logic reset;
    logic send;
    logic abort;
    logic ser_in;
    logic ld, en, tx_bit, tx_valid, busy, done;

    logic [MSG_W-1:0] msg_val;
    logic [MSG_W-1:0] sr;

    sym_t sym_q[$];
    int   done_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int   sym_tick = 0;
    int   busy_run = 0;
    int   en_cnt   = 0;
    sym_t mon_sym;
    int   exp_len;

    always #5 clk = ~clk;

    mod_tx_sequencer u_dut (
        .clk      (clk),
        .reset    (reset),
        .send     (send),
        .abort    (abort),
        .ser_in   (ser_in),
        .ld       (ld),
        .en       (en),
        .tx_bit   (tx_bit),
        .tx_valid (tx_valid),
        .busy     (busy),
        .done     (done)
    );

    // Message shift register, MSB first
    always @(posedge clk or negedge reset) begin
        if (!reset) sr <= '0;
        else if (ld) sr <= msg_val;
        else if (en) sr <= {sr[MSG_W-2:0], 1'b0};
    end
    assign ser_in = sr[MSG_W-1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [MSG_W-1:0] m);
        sym_t s;
        for (int i = 0; i < int'(PRE_LEN); i++) begin
            s.b = ((i % 2) == 0);
            s.is_data = 1'b0;
            sym_q.push_back(s);
        end
        for (int i = int'(MSG_W) - 1; i >= 0; i--) begin
            s.b = m[i];
            s.is_data = 1'b1;
            sym_q.push_back(s);
        end
        s.b = ^m;
        s.is_data = 1'b0;
        sym_q.push_back(s);
        done_q.push_back(int'(FRAME_LEN));
    endtask

    task automatic start_frame(input logic [MSG_W-1:0] m);
        msg_val = m;
        push_frame(m);
        send = 1'b1;
        @(posedge clk);
        #1 send = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_eq("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_ld"}, 32'(ld), 32'd1);
        check_eq({tag, "_en"}, 32'(en), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_valid"}, 32'(tx_valid), 32'd0);
        check_eq({tag, "_bit"}, 32'(tx_bit), 32'd0);
    endtask

    // Output monitor: symbol stream, en placement, frame length and en count
    always @(negedge clk) begin
        if (!reset) begin
            sym_tick = 0;
            busy_run = 0;
            en_cnt   = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (done_q.size() == 0) begin
                    check_eq("done_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_len = done_q.pop_front();
                    check_eq("busy_len", 32'(busy_run), 32'(exp_len));
                    check_eq("en_count", 32'(en_cnt), 32'(MSG_W));
                end
            end
            if (!busy) begin
                busy_run = 0;
                en_cnt   = 0;
            end
            if (en) en_cnt++;
            if (tx_valid) begin
                if (sym_q.size() == 0) begin
                    check_eq("sym_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_sym = sym_q[0];
                    check_eq("tx_bit", 32'(tx_bit), 32'(mon_sym.b));
                    check_eq("en_pos", 32'(en),
                             32'(mon_sym.is_data && (sym_tick == int'(BIT_TICKS) - 1)));
                    if (sym_tick == int'(BIT_TICKS) - 1) begin
                        void'(sym_q.pop_front());
                        sym_tick = 0;
                    end else begin
                        sym_tick++;
                    end
                end
            end else begin
                sym_tick = 0;
                check_eq("en_invalid", 32'(en), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b0;
        send    = 1'b0;
        abort   = 1'b0;
        msg_val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("rst");
        check_eq("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Idle with no request
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_idle("idle");
            check_eq("idle_done", 32'(done), 32'd0);
        end

        // 0xA5 frame with exact done timing
        start_frame(8'hA5);
        repeat (FRAME_LEN - 1) @(posedge clk);
        @(negedge clk);
        check_eq("a5_last_busy", 32'(busy), 32'd1);
        check_eq("a5_last_done", 32'(done), 32'd0);
        @(negedge clk);
        check_eq("a5_done", 32'(done), 32'd1);
        check_idle("a5_end");
        @(negedge clk);
        check_eq("a5_done_once", 32'(done), 32'd0);

        // 0x07 frame, odd number of ones
        start_frame(8'h07);
        wait_done(100);
        @(negedge clk);

        // Back-to-back frames with send held high
        msg_val = 8'h3C;
        push_frame(8'h3C);
        push_frame(8'hFF);
        send = 1'b1;
        @(posedge clk);
        #1 msg_val = 8'hFF;
        wait_done(100);
        @(posedge clk);
        #1 send = 1'b0;
        @(negedge clk);
        check_eq("b2b_busy", 32'(busy), 32'd1);
        check_eq("b2b_valid", 32'(tx_valid), 32'd1);
        wait_done(100);
        @(negedge clk);

        // Abort at cycle 25 of a frame
        start_frame(8'hA5);
        repeat (24) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        sym_q.delete();
        done_q.delete();
        @(negedge clk);
        check_idle("abort");
        check_eq("abort_done", 32'(done), 32'd0);
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            check_eq("abort_no_done", 32'(done), 32'd0);
        end
        start_frame(8'h5A);
        wait_done(100);
        @(negedge clk);

        // Abort in IDLE blocks send
        send  = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 send = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check_eq("abort_idle_busy", 32'(busy), 32'd0);

        // send during DATA is ignored
        start_frame(8'hC3);
        repeat (30) @(posedge clk);
        #1 send = 1'b1;
        repeat (3) @(posedge clk);
        #1 send = 1'b0;
        wait_done(100);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("ignored_send_done", 32'(done), 32'd0);
            check_eq("ignored_send_busy", 32'(busy), 32'd0);
        end

        // Asynchronous reset mid-frame
        start_frame(8'h96);
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_idle("async_rst");
        check_eq("async_rst_done", 32'(done), 32'd0);
        sym_q.delete();
        done_q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_eq("post_rst_done", 32'(done), 32'd0);
        start_frame(8'h96);
        wait_done(100);
        @(negedge clk);

        check_eq("sym_q_empty", 32'(sym_q.size()), 32'd0);
        check_eq("done_q_empty", 32'(done_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_tx_sequencer.md
Name: mod_tx_sequencer

Overview:
Frame-level controller for the bit-serial digital modulation transmit path. It drives the message shift register's ld/en controls and samples its serial output. It builds a frame of alternating preamble, message bits, an even-parity bit and an idle gap. It presents tx_bit/tx_valid to the modulator, holding each symbol for a fixed number of clock ticks.

Parameters:
MSG_W, 8, message width in bits (shift register length)
BIT_TICKS, 4, clock cycles per transmitted symbol (>=2)
PRE_LEN, 4, preamble symbols, pattern 1,0,1,0,...
GAP_TICKS, 8, idle cycles after the parity bit before done (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset (0 = reset)
send  input  1  level request to start a frame, sampled in IDLE
abort  input  1  synchronous abort of a frame in progress
ser_in  input  1  current serial bit from the message shift register (MSB first)
ld  output  1  load message shift register (high in IDLE)
en  output  1  shift-enable strobe, one cycle per data bit
tx_bit  output  1  symbol to modulator
tx_valid  output  1  high while a preamble, data or parity symbol is driven
busy  output  1  high in every non-IDLE state
done  output  1  registered one-cycle pulse at normal frame completion

Behaviour:
- Reset (reset=0, async): state=IDLE; tick_cnt, bit_cnt and parity cleared; done=0. Outputs then read ld=1, en=0, busy=0, tx_valid=0, tx_bit=0.
- States: IDLE, PRE, DATA, PAR, GAP. ld, en, busy, tx_bit and tx_valid are decoded combinationally from state, counters and ser_in.
- tick_cnt counts 0..BIT_TICKS-1 in PRE/DATA/PAR. bit_end = (tick_cnt==BIT_TICKS-1). In GAP, tick_cnt counts 0..GAP_TICKS-1.
- IDLE: ld=1, en=0, tx_valid=0, tx_bit=0.
  - send=1 and abort=0 at posedge -> PRE; tick_cnt, bit_cnt and parity cleared.
- PRE: tx_valid=1, tx_bit=~bit_cnt[0].
  - On bit_end: bit_cnt++.
  - When bit_cnt==PRE_LEN-1 and bit_end -> DATA, bit_cnt=0.
- DATA: ld=0, tx_valid=1, tx_bit=ser_in.
  - en=1 only on bit_end cycles; parity^=ser_in on the same edge.
  - After MSG_W bits -> PAR.
  - Exactly MSG_W en pulses per frame. en is 0 in all other states.
- PAR: tx_valid=1, tx_bit=parity (even parity over the MSG_W data bits), held BIT_TICKS cycles -> GAP.
- GAP: tx_valid=0, tx_bit=0, busy=1, held GAP_TICKS cycles -> IDLE. done=1 in the first IDLE cycle only.
- Frame length: busy is high for (PRE_LEN+MSG_W+1)*BIT_TICKS+GAP_TICKS cycles, which is 60 with defaults.
- send while busy: ignored, no queuing. If send is still high in the IDLE cycle carrying done, a new frame starts at that edge (back-to-back allowed).
- abort=1 in any non-IDLE state: next state IDLE, counters cleared, done is not pulsed.
  - abort takes priority over every other transition.
  - abort=1 in IDLE blocks send that cycle.
- Async reset mid-frame: immediate return to IDLE with reset values. No done pulse.
- Counter widths: $clog2 of the max count plus 1. Counters must not wrap inside a state.

Decomposition:
- Shared package mod_pkg holds:
  - the state encoding localparams (IDLE, PRE, DATA, PAR, GAP; 3-bit)
  - default MSG_W, BIT_TICKS, PRE_LEN and GAP_TICKS values, shared with the shift register and modulator.
- One sub-module, mod_bit_timer: a loadable tick counter with clear, a terminal-count input and a bit_end strobe output. It is instantiated once and reused for the symbol and gap timing.

Test Plan:
- Reset then idle with send=0 for 20 cycles -> ld=1, en=0, busy=0, tx_valid=0, done=0 throughout. Async reset assertion mid-cycle clears state immediately.
- msg 0xA5, send pulse 1 cycle, defaults -> tx_bit sequence per 4-cycle symbol: 1010, 10100101, parity 0. Exactly 8 en pulses, each on a symbol's 4th cycle. busy for 60 cycles. done high 1 cycle at cycle 61.
- msg 0x07 -> data symbols 00000111, parity symbol 1. The rest as above.
- send held high continuously, two frames 0x3C then 0xFF -> second frame's PRE starts in the done cycle. No idle gap beyond GAP_TICKS. Parities 0 and 0.
- abort asserted at cycle 25 of a frame -> IDLE next cycle, busy=0, ld=1, no done. A following send starts a clean frame with the full preamble.
- send asserted during DATA of a frame -> ignored. Only one done, after 60 cycles.
